// File: rtl/icache_assoc.sv
// icache_assoc: read-only N-way set-associative instruction cache between fetch and a burst read port.
// Latency: hit returns data the cycle after acceptance (1 word/cycle streaming); miss costs AR + full line refill + 1.
// Backpressure: cpu_req_ready drops on miss, refill and invalidation; AR held stable until mem_ar_ready.
//
// Ports:
//   clk, resetn           clock, synchronous active-low reset
//   cpu_req_*/cpu_addr    fetch request (valid/ready), word address
//   cpu_rvalid/cpu_rdata  one response pulse per accepted request
//   inv_all/inv_busy      whole-cache invalidate pulse / walk in progress
//   mem_ar_*/mem_r_*      burst read request and beat channels
//   hit_cnt/miss_cnt      saturating event counters
module icache_assoc #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 5,
  parameter int INDEX_W  = 7,
  parameter int WAYS     = 2
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              cpu_req_valid,
  output logic              cpu_req_ready,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rvalid,
  output logic [31:0]       cpu_rdata,
  input  logic              inv_all,
  output logic              inv_busy,
  output logic              mem_ar_valid,
  input  logic              mem_ar_ready,
  output logic [ADDR_W-1:0] mem_ar_addr,
  output logic [7:0]        mem_ar_len,
  input  logic              mem_r_valid,
  input  logic [31:0]       mem_r_data,
  input  logic              mem_r_last,
  output logic              mem_r_ready,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WORD_W = OFFSET_W - 2;
  localparam int WORDS  = 1 << WORD_W;
  localparam int SETS   = 1 << INDEX_W;
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [2:0] {IDLE, LOOKUP, MISS_AR, REFILL, RESP, INV} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   addr_q;
  logic [WAYS-1:0]     valid [SETS];
  logic [WAY_W-1:0]    vptr  [SETS];
  logic [WAYS-1:0]     valid_q;
  logic [WAY_W-1:0]    victim_q;
  logic [WAY_W-1:0]    victim;
  logic [WORD_W-1:0]   beat_q;
  logic [INDEX_W-1:0]  inv_idx;
  logic                inv_pend;
  logic [31:0]         resp_q;
  logic [31:0]         rdata_hold;
  logic [31:0]         rdata_now;
  logic [31:0]         hit_data;
  logic                hit;
  logic                accept;
  logic                inv_req;
  logic                fill_we;
  logic [TAG_W-1:0]    tag_rd  [WAYS];
  logic [31:0]         data_rd [WAYS];

  wire [TAG_W-1:0]   req_tag  = addr_q[ADDR_W-1 -: TAG_W];
  wire [INDEX_W-1:0] req_idx  = addr_q[OFFSET_W +: INDEX_W];
  wire [WORD_W-1:0]  req_word = addr_q[2 +: WORD_W];
  wire [INDEX_W-1:0] in_idx   = cpu_addr[OFFSET_W +: INDEX_W];
  wire [WORD_W-1:0]  in_word  = cpu_addr[2 +: WORD_W];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[1:0], addr_q[1:0]};

  // Pending invalidation (new pulse or one latched during a miss) blocks new requests.
  assign inv_req       = inv_all | inv_pend;
  assign cpu_req_ready = resetn & ~inv_req & ((state == IDLE) | ((state == LOOKUP) & hit));
  assign accept        = cpu_req_valid & cpu_req_ready;
  assign cpu_rvalid    = ((state == LOOKUP) & hit) | (state == RESP);
  assign rdata_now     = (state == RESP) ? resp_q : hit_data;
  assign cpu_rdata     = cpu_rvalid ? rdata_now : rdata_hold;
  assign mem_ar_valid  = (state == MISS_AR);
  assign mem_ar_addr   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
  assign mem_ar_len    = 8'(WORDS - 1);
  assign mem_r_ready   = (state == REFILL);
  assign inv_busy      = (state == INV);
  assign fill_we       = resetn & (state == REFILL) & mem_r_valid;

  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[w] && tag_rd[w] == req_tag) begin
        hit      = 1'b1;
        hit_data = data_rd[w];
      end
    end
  end

  // Lowest-numbered invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    victim = vptr[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w]) victim = WAY_W'(w);
    end
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    logic [TAG_W-1:0] tag_ram  [SETS];
    logic [31:0]      data_ram [SETS*WORDS];
    logic [TAG_W-1:0] tag_q;
    logic [31:0]      data_q;

    always_ff @(posedge clk) begin
      if (fill_we && victim_q == WAY_W'(w)) begin
        data_ram[{req_idx, beat_q}] <= mem_r_data;
        if (mem_r_last) tag_ram[req_idx] <= req_tag;
      end
      if (accept) begin
        tag_q  <= tag_ram[in_idx];
        data_q <= data_ram[{in_idx, in_word}];
      end
    end

    assign tag_rd[w]  = tag_q;
    assign data_rd[w] = data_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      addr_q     <= '0;
      valid_q    <= '0;
      victim_q   <= '0;
      beat_q     <= '0;
      inv_idx    <= '0;
      inv_pend   <= 1'b0;
      resp_q     <= '0;
      rdata_hold <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid[s] <= '0;
        vptr[s]  <= '0;
      end
    end else begin
      if (cpu_rvalid) rdata_hold <= rdata_now;
      if (accept) begin
        addr_q  <= cpu_addr;
        valid_q <= valid[in_idx];
      end
      if (inv_all) inv_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (inv_req) begin
            state    <= INV;
            inv_idx  <= '0;
            inv_pend <= 1'b0;
          end else if (accept) begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            hit_cnt <= (hit_cnt == 32'hFFFF_FFFF) ? hit_cnt : hit_cnt + 32'd1;
            if (inv_req) begin
              state    <= INV;
              inv_idx  <= '0;
              inv_pend <= 1'b0;
            end else if (!accept) begin
              state <= IDLE;
            end
          end else begin
            miss_cnt <= (miss_cnt == 32'hFFFF_FFFF) ? miss_cnt : miss_cnt + 32'd1;
            victim_q <= victim;
            beat_q   <= '0;
            state    <= MISS_AR;
          end
        end
        MISS_AR: if (mem_ar_ready) state <= REFILL;
        REFILL: begin
          if (mem_r_valid) begin
            if (beat_q == req_word) resp_q <= mem_r_data;
            beat_q <= beat_q + 1'b1;
            // Valid is set on the last beat regardless of beat count.
            if (mem_r_last) begin
              valid[req_idx][victim_q] <= 1'b1;
              vptr[req_idx] <= (vptr[req_idx] == WAY_W'(WAYS - 1)) ? '0 : vptr[req_idx] + 1'b1;
              state <= RESP;
            end
          end
        end
        RESP: begin
          if (inv_req) begin
            state    <= INV;
            inv_idx  <= '0;
            inv_pend <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        INV: begin
          valid[inv_idx] <= '0;
          inv_idx        <= inv_idx + 1'b1;
          if (inv_idx == {INDEX_W{1'b1}}) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed bench for icache_assoc with an inline burst-memory model and response scoreboard.
// Memory returns (line_base >> 4) + beat for each beat; expected words are queued on request acceptance.
// Outputs are sampled on the falling clock edge; inputs change 1 time unit after the rising edge.
module tb_icache_assoc;
  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req_valid;
  logic        cpu_req_ready;
  logic [31:0] cpu_addr;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        inv_all;
  logic        inv_busy;
  logic        mem_ar_valid;
  logic        mem_ar_ready;
  logic [31:0] mem_ar_addr;
  logic [7:0]  mem_ar_len;
  logic        mem_r_valid;
  logic [31:0] mem_r_data;
  logic        mem_r_last;
  logic        mem_r_ready;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  always #5 clk = ~clk;

  icache_assoc #(.ADDR_W(32), .OFFSET_W(5), .INDEX_W(7), .WAYS(2)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_addr(cpu_addr),
    .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .inv_all(inv_all), .inv_busy(inv_busy),
    .mem_ar_valid(mem_ar_valid), .mem_ar_ready(mem_ar_ready), .mem_ar_addr(mem_ar_addr),
    .mem_ar_len(mem_ar_len), .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data),
    .mem_r_last(mem_r_last), .mem_r_ready(mem_r_ready),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  int          ar_wait = 0;
  int          ar_stall = 0;
  int          ar_cnt = 0;
  logic [31:0] ar_base = '0;
  logic [31:0] exp_ar_addr = '0;
  logic        r_pend = 1'b0;
  int          beat_idx = 0;
  logic        rst_arm = 1'b0;
  logic        s_rready = 1'b0;
  logic        acc = 1'b0;
  int          cyc = 0;
  int          rv_cnt = 0;
  int          rv_first = 0;
  int          rv_last = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample/drive at the falling edge, then advance past the rising edge.
  task automatic tick();
    logic ar_hs, r_hs;
    @(negedge clk);
    if (mem_ar_valid) begin
      chk("ar_addr", mem_ar_addr, exp_ar_addr);
      chk("ar_len", {24'h0, mem_ar_len}, 32'd7);
      chk("req_ready_during_ar", {31'h0, cpu_req_ready}, 32'd0);
      if (ar_wait > 0) begin
        mem_ar_ready = 1'b0;
        ar_wait--;
        ar_stall++;
      end else begin
        mem_ar_ready = 1'b1;
      end
    end else begin
      mem_ar_ready = 1'b0;
    end
    if (r_pend) begin
      mem_r_valid = 1'b1;
      mem_r_data  = (ar_base >> 4) + 32'(beat_idx);
      mem_r_last  = (beat_idx == 7);
      if (rst_arm && beat_idx == 3) begin
        resetn  = 1'b0;
        rst_arm = 1'b0;
      end
    end else begin
      mem_r_valid = 1'b0;
      mem_r_last  = 1'b0;
    end
    s_rready = mem_r_ready;
    acc      = cpu_req_valid & cpu_req_ready;
    if (cpu_rvalid) begin
      rv_cnt++;
      if (rv_cnt == 1) rv_first = cyc;
      rv_last = cyc;
      if (exp_q.size() == 0) chk("spurious_rvalid", {31'h0, cpu_rvalid}, 32'd0);
      else chk("rdata", cpu_rdata, exp_q.pop_front());
    end
    ar_hs = mem_ar_valid & mem_ar_ready;
    r_hs  = r_pend & mem_r_ready;
    if (ar_hs) ar_base = mem_ar_addr;
    @(posedge clk);
    #1;
    cyc++;
    if (ar_hs) begin
      ar_cnt++;
      r_pend   = 1'b1;
      beat_idx = 0;
    end
    if (r_hs) begin
      if (beat_idx == 7) r_pend = 1'b0;
      beat_idx++;
    end
  endtask

  task automatic send(input logic [31:0] addr, input logic [31:0] exp);
    cpu_req_valid = 1'b1;
    cpu_addr      = addr;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (acc) break;
    end
    chk("req_accepted", {31'h0, acc}, 32'd1);
    if (acc) exp_q.push_back(exp);
  endtask

  task automatic drain();
    cpu_req_valid = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
    chk("responses_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rvalid"},   {31'h0, cpu_rvalid},    32'd0);
    chk({tag, "_ar_valid"}, {31'h0, mem_ar_valid},  32'd0);
    chk({tag, "_r_ready"},  {31'h0, mem_r_ready},   32'd0);
    chk({tag, "_inv_busy"}, {31'h0, inv_busy},      32'd0);
    chk({tag, "_req_rdy"},  {31'h0, cpu_req_ready}, 32'd0);
    chk({tag, "_hit_cnt"},  hit_cnt,  32'd0);
    chk({tag, "_miss_cnt"}, miss_cnt, 32'd0);
  endtask

  initial begin
    int n, bad_ready;
    resetn = 1'b0; cpu_req_valid = 1'b0; cpu_addr = '0; inv_all = 1'b0;
    mem_ar_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0; mem_r_last = 1'b0;
    repeat (3) tick();
    chk_reset_outputs("reset");
    resetn = 1'b1;

    // Cold miss with 3-cycle AR delay.
    ar_wait = 3; exp_ar_addr = 32'h1000;
    send(32'h1004, 32'h101);
    drain();
    chk("t1_ar_cnt", 32'(ar_cnt), 32'd1);
    chk("t1_miss_cnt", miss_cnt, 32'd1);
    chk("t1_hit_cnt", hit_cnt, 32'd0);

    // Back-to-back hits across the filled line.
    rv_cnt = 0;
    for (int i = 0; i < 8; i++) send(32'h1000 + 32'(4 * i), 32'h100 + 32'(i));
    drain();
    chk("t2_rvalid_pulses", 32'(rv_cnt), 32'd8);
    chk("t2_consecutive", 32'(rv_last - rv_first), 32'd7);
    chk("t2_hit_cnt", hit_cnt, 32'd8);
    chk("t2_no_ar", 32'(ar_cnt), 32'd1);

    // Fresh cache: three tags in set 0 then the first again.
    resetn = 1'b0; tick(); tick(); resetn = 1'b1;
    ar_cnt = 0;
    exp_ar_addr = 32'h0000; send(32'h0000, 32'h000); drain();
    exp_ar_addr = 32'h1000; send(32'h1000, 32'h100); drain();
    exp_ar_addr = 32'h2000; send(32'h2000, 32'h200); drain();
    exp_ar_addr = 32'h0000; send(32'h0000, 32'h000); drain();
    chk("t3_miss_cnt", miss_cnt, 32'd4);
    chk("t3_ar_cnt", 32'(ar_cnt), 32'd4);
    // Fourth fill used the pointer (way 1), so 0x2000 in way 0 must still hit.
    send(32'h2004, 32'h201); drain();
    chk("t3_way0_kept_hit", hit_cnt, 32'd1);
    chk("t3_way0_kept_miss", miss_cnt, 32'd4);

    // Whole-cache invalidation.
    inv_all = 1'b1; tick(); inv_all = 1'b0;
    n = 0; bad_ready = 0;
    while (inv_busy && n < 300) begin
      n++;
      if (cpu_req_ready) bad_ready++;
      tick();
    end
    chk("t4_inv_busy_cycles", 32'(n), 32'd128);
    chk("t4_ready_in_inv", 32'(bad_ready), 32'd0);
    exp_ar_addr = 32'h2000; send(32'h2004, 32'h201); drain();
    exp_ar_addr = 32'h1000; send(32'h1004, 32'h101); drain();
    chk("t4_miss_after_inv", miss_cnt, 32'd6);
    chk("t4_ar_cnt", 32'(ar_cnt), 32'd6);

    // AR stalled for 20 cycles; address/ready are checked each stalled cycle inside tick.
    ar_wait = 20; ar_stall = 0; exp_ar_addr = 32'h3000;
    send(32'h3008, 32'h302); drain();
    chk("t5_ar_stall_cycles", 32'(ar_stall), 32'd20);
    chk("t5_miss_cnt", miss_cnt, 32'd7);

    // Reset pulse during the 4th refill beat.
    rst_arm = 1'b1; exp_ar_addr = 32'h4000;
    send(32'h4010, 32'h404);
    cpu_req_valid = 1'b0;
    n = 0;
    while (resetn && n < 100) begin tick(); n++; end
    chk("t6_reset_hit", {31'h0, resetn}, 32'd0);
    chk_reset_outputs("t6");
    exp_q.delete();
    resetn = 1'b1;
    tick();
    chk("t6_no_beat_after_rst", {31'h0, s_rready}, 32'd0);
    r_pend = 1'b0;
    ar_cnt = 0;
    send(32'h4010, 32'h404); drain();
    chk("t6_refill_miss", miss_cnt, 32'd1);
    chk("t6_refill_ar", 32'(ar_cnt), 32'd1);
    send(32'h4000, 32'h400); drain();
    chk("t6_line_valid_hit", hit_cnt, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
